// File: rtl/gfx_clip_zcmp.sv
// gfx_clip_zcmp: culls pixels against target/clip rects, then depth-tests them against the z-buffer with optional write-back
module gfx_clip_zcmp #(
   parameter int POINT_WIDTH = 16,
   parameter int Z_WIDTH     = 16,
   parameter int SW          = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clipping_enable_i,
   input  logic                   zbuffer_enable_i,
   input  logic                   zwrite_enable_i,
   input  logic [2:0]             zfunc_i,
   input  logic [31:0]            zbuffer_base_i,
   input  logic [POINT_WIDTH-1:0] target_size_x_i,
   input  logic [POINT_WIDTH-1:0] target_x0_i,
   input  logic [POINT_WIDTH-1:0] target_y0_i,
   input  logic [POINT_WIDTH-1:0] target_x1_i,
   input  logic [POINT_WIDTH-1:0] target_y1_i,
   input  logic [POINT_WIDTH-1:0] clip_x0_i,
   input  logic [POINT_WIDTH-1:0] clip_y0_i,
   input  logic [POINT_WIDTH-1:0] clip_x1_i,
   input  logic [POINT_WIDTH-1:0] clip_y1_i,
   input  logic                   in_write_i,
   input  logic                   in_has_z_i,
   input  logic [POINT_WIDTH-1:0] in_x_i,
   input  logic [POINT_WIDTH-1:0] in_y_i,
   input  logic [POINT_WIDTH-1:0] in_u_i,
   input  logic [POINT_WIDTH-1:0] in_v_i,
   input  logic [Z_WIDTH-1:0]     in_z_i,
   input  logic [7:0]             in_a_i,
   input  logic [31:0]            in_color_i,
   output logic                   ack_o,
   output logic                   z_request_o,
   output logic [31:0]            z_addr_o,
   input  logic                   z_ack_i,
   input  logic [SW-1:0]          z_data_i,
   input  logic                   wbm_busy_i,
   output logic                   zw_request_o,
   output logic [SW-1:0]          zw_data_o,
   output logic [SW/8-1:0]        zw_sel_o,
   input  logic                   zw_ack_i,
   output logic                   write_o,
   input  logic                   ack_i,
   output logic [POINT_WIDTH-1:0] pixel_x_o,
   output logic [POINT_WIDTH-1:0] pixel_y_o,
   output logic [POINT_WIDTH-1:0] u_o,
   output logic [POINT_WIDTH-1:0] v_o,
   output logic [Z_WIDTH-1:0]     pixel_z_o,
   output logic [7:0]             a_o,
   output logic [31:0]            color_o,
   input  logic                   stat_clear_i,
   output logic [31:0]            stat_pass_o,
   output logic [31:0]            stat_clip_o,
   output logic [31:0]            stat_zfail_o
);
   localparam int ZB   = Z_WIDTH / 8;
   localparam int ZSH  = (Z_WIDTH == 32) ? 2 : 1;
   localparam int NL   = SW / Z_WIDTH;
   localparam int OFFW = $clog2(SW / 8);
   localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
   localparam logic [31:0] SAT = '1;

   typedef enum logic [2:0] {IDLE, ADDR, ZREAD, ZWRITE, OUT} state_t;

   state_t                 state_q, state_d;
   logic [POINT_WIDTH-1:0] x_q, x_d, y_q, y_d, u_q, u_d, v_q, v_d;
   logic [Z_WIDTH-1:0]     z_q, z_d;
   logic [7:0]             a_q, a_d;
   logic [31:0]            color_q, color_d;
   logic [31:0]            zaddr_q, zaddr_d;
   logic [LW-1:0]          lane_q, lane_d;
   logic [SW/8-1:0]        sel_q, sel_d;
   logic                   zreq_q, zreq_d, zwreq_q, zwreq_d, write_q, write_d, ack_q, ack_d;
   logic [31:0]            pass_q, pass_d, clip_q, clip_d, zfail_q, zfail_d;
   logic                   inc_pass, inc_clip, inc_zfail;

   logic [31:0]            pix_idx, byte_addr;
   logic [LW-1:0]          lane_n;
   logic [SW/8-1:0]        sel_n;
   logic [Z_WIDTH-1:0]     stored_z;
   logic                   z_lt, z_eq, zpass, out_tgt, out_clip, discard;
   logic [7:0]             zf_tab;

   assign pix_idx   = 32'(y_q) * 32'(target_size_x_i) + 32'(x_q);
   assign byte_addr = zbuffer_base_i + (pix_idx << ZSH);
   assign lane_n    = LW'(byte_addr[OFFW-1:0] >> ZSH);

   assign out_tgt  = in_x_i < target_x0_i || in_x_i >= target_x1_i || in_y_i < target_y0_i || in_y_i >= target_y1_i;
   assign out_clip = in_x_i < clip_x0_i || in_x_i >= clip_x1_i || in_y_i < clip_y0_i || in_y_i >= clip_y1_i;
   assign discard  = out_tgt || (clipping_enable_i && out_clip);

   // byte enables covering the z lane of the pixel being addressed
   always_comb begin
      sel_n = '0;
      for (int i = 0; i < NL; i++) if (lane_n == LW'(i)) sel_n[i*ZB +: ZB] = '1;
   end

   // stored depth picked out of the returned bus word
   always_comb begin
      stored_z = '0;
      for (int i = 0; i < NL; i++) if (lane_q == LW'(i)) stored_z = z_data_i[i*Z_WIDTH +: Z_WIDTH];
   end

   assign z_lt   = $signed(z_q) < $signed(stored_z);
   assign z_eq   = z_q == stored_z;
   assign zf_tab = {1'b1, !z_lt, !z_eq, !(z_lt || z_eq), z_lt || z_eq, z_eq, z_lt, 1'b0};
   assign zpass  = zf_tab[zfunc_i];

   // next state, latched attributes, handshakes and counter increments
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      u_d       = u_q;
      v_d       = v_q;
      z_d       = z_q;
      a_d       = a_q;
      color_d   = color_q;
      zaddr_d   = zaddr_q;
      lane_d    = lane_q;
      sel_d     = sel_q;
      zreq_d    = zreq_q;
      zwreq_d   = zwreq_q;
      write_d   = write_q;
      ack_d     = 1'b0;
      inc_pass  = 1'b0;
      inc_clip  = 1'b0;
      inc_zfail = 1'b0;
      case (state_q)
         IDLE: if (in_write_i) begin
            x_d     = in_x_i;
            y_d     = in_y_i;
            u_d     = in_u_i;
            v_d     = in_v_i;
            z_d     = in_has_z_i ? in_z_i : '0;
            a_d     = in_a_i;
            color_d = in_color_i;
            if (discard) begin
               ack_d    = 1'b1;
               inc_clip = 1'b1;
            end else if (zbuffer_enable_i && in_has_z_i) begin
               state_d = ADDR;
            end else begin
               write_d = 1'b1;
               state_d = OUT;
            end
         end
         ADDR: begin
            zaddr_d = {byte_addr[31:OFFW], {OFFW{1'b0}}};
            lane_d  = lane_n;
            sel_d   = sel_n;
            zreq_d  = !wbm_busy_i;
            state_d = ZREAD;
         end
         ZREAD: if (zreq_q && z_ack_i) begin
            zreq_d = 1'b0;
            if (!zpass) begin
               ack_d     = 1'b1;
               inc_zfail = 1'b1;
               state_d   = IDLE;
            end else if (zwrite_enable_i) begin
               zwreq_d = 1'b1;
               state_d = ZWRITE;
            end else begin
               write_d = 1'b1;
               state_d = OUT;
            end
         end else begin
            zreq_d = zreq_q || !wbm_busy_i;
         end
         ZWRITE: if (zw_ack_i) begin
            zwreq_d = 1'b0;
            write_d = 1'b1;
            state_d = OUT;
         end
         OUT: if (ack_i) begin
            write_d  = 1'b0;
            ack_d    = 1'b1;
            inc_pass = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      pass_d  = stat_clear_i ? '0 : (inc_pass && pass_q != SAT) ? pass_q + 32'd1 : pass_q;
      clip_d  = stat_clear_i ? '0 : (inc_clip && clip_q != SAT) ? clip_q + 32'd1 : clip_q;
      zfail_d = stat_clear_i ? '0 : (inc_zfail && zfail_q != SAT) ? zfail_q + 32'd1 : zfail_q;
   end

   // state and datapath registers; reset clears every output immediately
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         v_q     <= '0;
         z_q     <= '0;
         a_q     <= '0;
         color_q <= '0;
         zaddr_q <= '0;
         lane_q  <= '0;
         sel_q   <= '0;
         zreq_q  <= 1'b0;
         zwreq_q <= 1'b0;
         write_q <= 1'b0;
         ack_q   <= 1'b0;
         pass_q  <= '0;
         clip_q  <= '0;
         zfail_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         u_q     <= u_d;
         v_q     <= v_d;
         z_q     <= z_d;
         a_q     <= a_d;
         color_q <= color_d;
         zaddr_q <= zaddr_d;
         lane_q  <= lane_d;
         sel_q   <= sel_d;
         zreq_q  <= zreq_d;
         zwreq_q <= zwreq_d;
         write_q <= write_d;
         ack_q   <= ack_d;
         pass_q  <= pass_d;
         clip_q  <= clip_d;
         zfail_q <= zfail_d;
      end
   end

   assign ack_o        = ack_q;
   assign z_request_o  = zreq_q;
   assign z_addr_o     = zaddr_q;
   assign zw_request_o = zwreq_q;
   assign zw_data_o    = {NL{z_q}};
   assign zw_sel_o     = sel_q;
   assign write_o      = write_q;
   assign pixel_x_o    = x_q;
   assign pixel_y_o    = y_q;
   assign u_o          = u_q;
   assign v_o          = v_q;
   assign pixel_z_o    = z_q;
   assign a_o          = a_q;
   assign color_o      = color_q;
   assign stat_pass_o  = pass_q;
   assign stat_clip_o  = clip_q;
   assign stat_zfail_o = zfail_q;
endmodule

// File: tb/tb_gfx_clip_zcmp.sv
// tb_gfx_clip_zcmp: scoreboard bench for the clip / depth-test stage
module tb_gfx_clip_zcmp;
   localparam int PW = 16;
   localparam int ZW = 16;
   localparam int SW = 256;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          clipping_enable_i = 1'b0, zbuffer_enable_i = 1'b0, zwrite_enable_i = 1'b0;
   logic [2:0]    zfunc_i = '0;
   logic [31:0]   zbuffer_base_i = '0;
   logic [PW-1:0] target_size_x_i = '0;
   logic [PW-1:0] target_x0_i = '0, target_y0_i = '0, target_x1_i = '0, target_y1_i = '0;
   logic [PW-1:0] clip_x0_i = '0, clip_y0_i = '0, clip_x1_i = '0, clip_y1_i = '0;
   logic          in_write_i = 1'b0, in_has_z_i = 1'b0;
   logic [PW-1:0] in_x_i = '0, in_y_i = '0, in_u_i = '0, in_v_i = '0;
   logic [ZW-1:0] in_z_i = '0;
   logic [7:0]    in_a_i = '0;
   logic [31:0]   in_color_i = '0;
   logic          ack_o, z_request_o, zw_request_o, write_o;
   logic [31:0]   z_addr_o;
   logic          z_ack_i = 1'b0, wbm_busy_i = 1'b0, zw_ack_i = 1'b0, ack_i = 1'b0, stat_clear_i = 1'b0;
   logic [SW-1:0] z_data_i = '0;
   logic [SW-1:0] zw_data_o;
   logic [SW/8-1:0] zw_sel_o;
   logic [PW-1:0] pixel_x_o, pixel_y_o, u_o, v_o;
   logic [ZW-1:0] pixel_z_o;
   logic [7:0]    a_o;
   logic [31:0]   color_o, stat_pass_o, stat_clip_o, stat_zfail_o;

   gfx_clip_zcmp #(.POINT_WIDTH(PW), .Z_WIDTH(ZW), .SW(SW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .clipping_enable_i(clipping_enable_i), .zbuffer_enable_i(zbuffer_enable_i), .zwrite_enable_i(zwrite_enable_i),
      .zfunc_i(zfunc_i), .zbuffer_base_i(zbuffer_base_i), .target_size_x_i(target_size_x_i),
      .target_x0_i(target_x0_i), .target_y0_i(target_y0_i), .target_x1_i(target_x1_i), .target_y1_i(target_y1_i),
      .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i), .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
      .in_write_i(in_write_i), .in_has_z_i(in_has_z_i), .in_x_i(in_x_i), .in_y_i(in_y_i),
      .in_u_i(in_u_i), .in_v_i(in_v_i), .in_z_i(in_z_i), .in_a_i(in_a_i), .in_color_i(in_color_i),
      .ack_o(ack_o), .z_request_o(z_request_o), .z_addr_o(z_addr_o), .z_ack_i(z_ack_i), .z_data_i(z_data_i),
      .wbm_busy_i(wbm_busy_i), .zw_request_o(zw_request_o), .zw_data_o(zw_data_o), .zw_sel_o(zw_sel_o),
      .zw_ack_i(zw_ack_i), .write_o(write_o), .ack_i(ack_i),
      .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .u_o(u_o), .v_o(v_o), .pixel_z_o(pixel_z_o),
      .a_o(a_o), .color_o(color_o), .stat_clear_i(stat_clear_i),
      .stat_pass_o(stat_pass_o), .stat_clip_o(stat_clip_o), .stat_zfail_o(stat_zfail_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          kind;
      int          cyc;
      int          rq;
      int          wq;
      logic [31:0] addr;
      logic [31:0] sel;
      logic [15:0] x, y, z;
      logic [31:0] color;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0, errors = 0;
   int           zlat = 0, wlat = 0, busy_len = 0;
   int           n_pass = 0, n_clip = 0, n_zfail = 0;
   logic [255:0] zword = '0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   function automatic bit zcmp(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (f)
         3'd0: return 1'b0;
         3'd1: return sa < sb;
         3'd2: return sa == sb;
         3'd3: return sa <= sb;
         3'd4: return sa > sb;
         3'd5: return sa != sb;
         3'd6: return sa >= sb;
         default: return 1'b1;
      endcase
   endfunction

   task automatic set_lanes(input int lane, input logic [15:0] val);
      for (int i = 0; i < 16; i++) zword[i*16 +: 16] = 16'h7ff0 + 16'(i);
      zword[lane*16 +: 16] = val;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_ctl"}, {ack_o, z_request_o, zw_request_o, write_o}, 0);
      chk({p, "_addr"}, z_addr_o, 0);
      chk({p, "_sel"}, zw_sel_o, 0);
      chk({p, "_data"}, zw_data_o, 0);
      chk({p, "_stats"}, {stat_pass_o, stat_clip_o, stat_zfail_o}, 0);
      chk({p, "_pix"}, {pixel_x_o, pixel_y_o, u_o, v_o, pixel_z_o, a_o, color_o}, 0);
   endtask

   task automatic run_pixel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic hz, input logic [31:0] col);
      exp_t         e, g;
      bit           disc, zt, pass, done;
      int           lane, dc, c, rq_seen, wq_seen, got_kind;
      logic [31:0]  ba, addr_seen, sel_seen;
      logic [255:0] data_seen;
      logic [15:0]  sz;
      disc = (x < target_x0_i) || (x >= target_x1_i) || (y < target_y0_i) || (y >= target_y1_i) ||
             (clipping_enable_i && ((x < clip_x0_i) || (x >= clip_x1_i) || (y < clip_y0_i) || (y >= clip_y1_i)));
      zt   = !disc && zbuffer_enable_i && hz;
      ba   = zbuffer_base_i + (32'(y) * 32'(target_size_x_i) + 32'(x)) * 2;
      lane = int'(ba[4:0]) / 2;
      sz   = zword[lane*16 +: 16];
      pass = !disc && (!zt || zcmp(zfunc_i, z, sz));
      e.kind  = pass ? 1 : 0;
      e.rq    = zt ? ((busy_len > 1) ? busy_len + 1 : 2) : 0;
      dc      = e.rq + zlat;
      e.wq    = (zt && pass && zwrite_enable_i) ? dc + 1 : 0;
      e.cyc   = !zt ? 1 : (e.wq != 0) ? e.wq + wlat + 1 : dc + 1;
      e.addr  = {ba[31:5], 5'b0};
      e.sel   = 32'h3 << (lane * 2);
      e.x     = x;
      e.y     = y;
      e.z     = hz ? z : 16'h0;
      e.color = col;
      if (disc) n_clip++;
      else if (!pass) n_zfail++;
      else n_pass++;
      exp_q.push_back(e);
      in_x_i = x; in_y_i = y; in_u_i = ~x; in_v_i = ~y; in_z_i = z; in_has_z_i = hz;
      in_a_i = col[7:0]; in_color_i = col; in_write_i = 1'b1;
      wbm_busy_i = busy_len > 0;
      rq_seen = 0; wq_seen = 0; done = 0; got_kind = -1; c = 0;
      addr_seen = '0; sel_seen = '0; data_seen = '0;
      while (!done && c < 100) begin
         tick;
         c++;
         wbm_busy_i = c < busy_len;
         if (z_request_o && rq_seen == 0) begin rq_seen = c; addr_seen = z_addr_o; end
         if (zw_request_o && wq_seen == 0) begin wq_seen = c; sel_seen = zw_sel_o; data_seen = zw_data_o; end
         if (write_o || ack_o) begin done = 1; got_kind = write_o ? 1 : 0; end
         z_ack_i  = z_request_o && rq_seen != 0 && c >= rq_seen + zlat;
         z_data_i = zword;
         zw_ack_i = zw_request_o && wq_seen != 0 && c >= wq_seen + wlat;
      end
      g = exp_q.pop_front();
      if (!done) chk("timeout", 0, 1);
      chk("kind", got_kind, g.kind);
      chk("cycle", c, g.cyc);
      chk("zreq_cycle", rq_seen, g.rq);
      if (g.rq != 0) chk("z_addr", addr_seen, g.addr);
      chk("zw_cycle", wq_seen, g.wq);
      if (g.wq != 0) begin
         chk("zw_sel", sel_seen, g.sel);
         chk("zw_data", data_seen, {16{g.z}});
      end
      if (got_kind == 1) begin
         chk("pix_xy", {pixel_y_o, pixel_x_o}, {g.y, g.x});
         chk("pix_uv", {v_o, u_o}, {~g.y, ~g.x});
         chk("pix_z", pixel_z_o, g.z);
         chk("pix_ac", {a_o, color_o}, {g.color[7:0], g.color});
         repeat (2) tick;
         chk("write_hold", {write_o, ack_o}, 2'b10);
         ack_i = 1'b1;
         tick;
         ack_i = 1'b0;
         chk("accept", {ack_o, write_o}, 2'b10);
      end
      in_write_i = 1'b0;
      wbm_busy_i = 1'b0;
      tick;
      chk("ack_pulse", ack_o, 0);
      chk("stat_pass", stat_pass_o, n_pass);
      chk("stat_clip", stat_clip_o, n_clip);
      chk("stat_zfail", stat_zfail_o, n_zfail);
   endtask

   initial begin
      #3;
      chk_zero("reset");
      target_x0_i = 0; target_y0_i = 0; target_x1_i = 640; target_y1_i = 480;
      target_size_x_i = 640; zbuffer_base_i = 32'h1000;
      clip_x0_i = 10; clip_y0_i = 10; clip_x1_i = 20; clip_y1_i = 20;
      tick;
      rst_i = 1'b1;
      tick;
      run_pixel(640, 10, 0, 0, 32'h11223344);
      run_pixel(639, 479, 0, 0, 32'h0a0b0c0d);
      run_pixel(5, 480, 0, 0, 32'h1);
      clipping_enable_i = 1'b1;
      run_pixel(15, 15, 0, 0, 32'hdeadbeef);
      run_pixel(20, 15, 0, 0, 32'h2);
      run_pixel(15, 9, 0, 0, 32'h3);
      run_pixel(10, 10, 0, 0, 32'h4);
      clipping_enable_i = 1'b0;
      zbuffer_enable_i = 1'b1;
      zfunc_i = 3'd3;
      set_lanes(3, 16'd7);
      run_pixel(3, 0, 16'd5, 1, 32'hcafef00d);
      set_lanes(3, 16'd4);
      run_pixel(3, 0, 16'd5, 1, 32'h5);
      zwrite_enable_i = 1'b1;
      set_lanes(3, 16'd7);
      zlat = 1; wlat = 2;
      run_pixel(3, 0, 16'd5, 1, 32'h6);
      zwrite_enable_i = 1'b0;
      zlat = 0; wlat = 0; busy_len = 7;
      run_pixel(3, 0, 16'd5, 1, 32'h7);
      busy_len = 0;
      zfunc_i = 3'd1; zwrite_enable_i = 1'b1; wlat = 1;
      set_lanes(4, 16'd2);
      run_pixel(100, 2, 16'hfffd, 1, 32'h8);
      zwrite_enable_i = 1'b0; wlat = 0;
      for (int f = 0; f < 8; f++) begin
         zfunc_i = 3'(f);
         zlat = f % 3;
         set_lanes(3, 16'd4); run_pixel(3, 0, 16'd5, 1, 32'h100 + 32'(f));
         set_lanes(3, 16'd5); run_pixel(3, 0, 16'd5, 1, 32'h200 + 32'(f));
         set_lanes(3, 16'd7); run_pixel(3, 0, 16'd5, 1, 32'h300 + 32'(f));
      end
      zlat = 0;
      zfunc_i = 3'd0;
      run_pixel(3, 0, 16'd5, 0, 32'h9);
      stat_clear_i = 1'b1;
      tick;
      stat_clear_i = 1'b0;
      n_pass = 0; n_clip = 0; n_zfail = 0;
      chk("stat_clear", {stat_pass_o, stat_clip_o, stat_zfail_o}, 0);
      zbuffer_enable_i = 1'b0;
      in_x_i = 1; in_y_i = 1; in_u_i = 2; in_v_i = 3; in_z_i = 4; in_has_z_i = 1'b1;
      in_a_i = 8'h55; in_color_i = 32'h77; in_write_i = 1'b1;
      tick;
      chk("out_write", write_o, 1);
      #2;
      rst_i = 1'b0;
      #1;
      chk_zero("mid_rst");
      in_write_i = 1'b0;
      tick;
      chk("mid_rst_hold", {ack_o, write_o}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
